ram_fifo_ctrl: RTL and testbench

//   Initiator-side controller for the single-write/single-read-port block RAM (DUALRAM).

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_fifo_arb.sv | 37 +++
 rtl/ram_fifo_ctrl.sv | 96 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared defaults and grant encoding for the DUALRAM FIFO controller.
package ram_pkg;

    localparam int unsigned DEF_MEM_WIDTH = 16;
    localparam int unsigned DEF_MEM_DEPTH = 1024;
    localparam int unsigned DEF_ADDR_SIZE = 10;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PUSH,
        GNT_POP
    } grant_t;

endpackage

// File: rtl/ram_fifo_arb.sv
// Two-way round-robin arbiter between push and pop; at most one grant per cycle.
module ram_fifo_arb
    import ram_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_ok_i,
    input  logic   pop_ok_i,
    output grant_t grant_o
);

    grant_t last_q;
    grant_t last_d;

    // last_grant only moves on a conflict, so a lone requester never steals the next turn.
    always_comb begin
        grant_o = GNT_NONE;
        last_d  = last_q;
        if (push_ok_i && pop_ok_i) begin
            grant_o = (last_q == GNT_PUSH) ? GNT_POP : GNT_PUSH;
            last_d  = grant_o;
        end else if (push_ok_i) begin
            grant_o = GNT_PUSH;
        end else if (pop_ok_i) begin
            grant_o = GNT_POP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= GNT_POP;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single DUALRAM: pointers, occupancy, flags, read-valid pipeline.
module ram_fifo_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push_req,
    input  logic [MEM_WIDTH-1:0] push_data,
    output logic                 push_ack,
    input  logic                 pop_req,
    output logic                 pop_ack,
    output logic [MEM_WIDTH-1:0] pop_data,
    output logic                 pop_data_vld,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_SIZE:0]   count,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic [ADDR_SIZE-1:0] ram_addr_wr,
    output logic [ADDR_SIZE-1:0] ram_addr_rd,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_blk_select,
    input  logic [MEM_WIDTH-1:0] ram_dout
);

    grant_t               grant;
    logic                 push_ok;
    logic                 pop_ok;
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 vld_q;

    assign full    = (count_q == (ADDR_SIZE+1)'(MEM_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_req & ~full & ~flush & ~rst;
    assign pop_ok  = pop_req & ~empty & ~flush & ~rst;

    ram_fifo_arb u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_ok_i (push_ok),
        .pop_ok_i  (pop_ok),
        .grant_o   (grant)
    );

    assign push_ack       = (grant == GNT_PUSH);
    assign pop_ack        = (grant == GNT_POP);
    assign ram_wr_en      = push_ack;
    assign ram_rd_en      = pop_ack;
    assign ram_blk_select = ram_wr_en | ram_rd_en;
    assign ram_din        = push_data;
    assign ram_addr_wr    = wr_ptr_q;
    assign ram_addr_rd    = rd_ptr_q;
    assign pop_data       = ram_dout;
    assign pop_data_vld   = vld_q;
    assign count          = count_q;

    // Explicit wrap compare keeps non-power-of-2 depths correct.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (push_ack) begin
            wr_ptr_d = (wr_ptr_q == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_SIZE'(1);
            count_d  = count_q + (ADDR_SIZE+1)'(1);
        end else if (pop_ack) begin
            rd_ptr_d = (rd_ptr_q == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_SIZE'(1);
            count_d  = count_q - (ADDR_SIZE+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= pop_ack;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl paired with a behavioural DUALRAM and a queue model.
module tb_ram_fifo_ctrl;
    import ram_pkg::*;

    localparam int W = 16;
    localparam int D = 1024;
    localparam int A = 10;

    logic         clk = 1'b0;
    logic         rst, flush, push_req, pop_req;
    logic [W-1:0] push_data, pop_data, ram_din, ram_dout;
    logic         push_ack, pop_ack, pop_data_vld, full, empty;
    logic [A:0]   count;
    logic [A-1:0] ram_addr_wr, ram_addr_rd;
    logic         ram_wr_en, ram_rd_en, ram_blk_select;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(A)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
        .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data), .pop_data_vld(pop_data_vld),
        .full(full), .empty(empty), .count(count),
        .ram_din(ram_din), .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_blk_select(ram_blk_select),
        .ram_dout(ram_dout)
    );

    // Behavioural DUALRAM: one op per cycle, write wins, registered read data.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (ram_blk_select) begin
            if (ram_wr_en) mem[ram_addr_wr] <= ram_din;
            else if (ram_rd_en) ram_dout <= mem[ram_addr_rd];
        end
    end

    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] mq[$];
    int           mwr = 0, mrd = 0;
    bit           mlast_push = 0;
    bit           exp_pa, exp_po, exp_vld;
    logic [W-1:0] exp_data;

    task automatic drive(input bit r, input bit pu, input logic [W-1:0] d, input bit po, input bit fl);
        bit pok, qok;
        @(negedge clk);
        rst = r; push_req = pu; push_data = d; pop_req = po; flush = fl;
        pok = pu && !r && !fl && (mq.size() < D);
        qok = po && !r && !fl && (mq.size() > 0);
        exp_pa = pok && (!qok || !mlast_push);
        exp_po = qok && (!pok || mlast_push);
        if (pok && qok) mlast_push = exp_pa;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            mq.delete(); mwr = 0; mrd = 0; exp_vld = 0; mlast_push = 0;
        end else begin
            exp_vld = exp_po;
            if (flush) begin
                mq.delete(); mwr = 0; mrd = 0;
            end else begin
                if (exp_pa) begin mq.push_back(push_data); mwr = (mwr + 1) % D; end
                if (exp_po) begin exp_data = mq.pop_front(); mrd = (mrd + 1) % D; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 16'hAAAA, 1, 0);
        n_checks++;
        if ({push_ack, pop_ack, ram_blk_select} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes got=%b want=000", {push_ack, pop_ack, ram_blk_select});
        end
        advance();
        drive(1, 0, '0, 0, 0);
        advance();
        n_checks++;
        if ({count, empty, full, pop_data_vld} !== {11'd0, 3'b100}) begin
            n_fail++; $display("FAIL reset_state count=%0d empty=%b full=%b vld=%b want 0/1/0/0",
                               count, empty, full, pop_data_vld);
        end
    endtask

    task automatic test_push4();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, W'(i + 1), 0, 0);
            n_checks++;
            if (push_ack !== 1'b1 || ram_wr_en !== 1'b1 || ram_addr_wr !== A'(i) || empty !== (i == 0)) begin
                n_fail++; $display("FAIL push4[%0d] ack=%b wr_en=%b addr=%0d empty=%b want 1/1/%0d/%b",
                                   i, push_ack, ram_wr_en, ram_addr_wr, empty, i, i == 0);
            end
            advance();
        end
        n_checks++;
        if (count !== 11'd4 || empty !== 1'b0) begin
            n_fail++; $display("FAIL push4_count got=%0d empty=%b want 4/0", count, empty);
        end
    endtask

    task automatic test_pop4();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0, 1, 0);
            n_checks++;
            if (pop_ack !== 1'b1 || ram_rd_en !== 1'b1 || ram_addr_rd !== A'(i)) begin
                n_fail++; $display("FAIL pop4_ack[%0d] ack=%b rd_en=%b addr=%0d want 1/1/%0d",
                                   i, pop_ack, ram_rd_en, ram_addr_rd, i);
            end
            advance();
            n_checks++;
            if (pop_data_vld !== 1'b1 || pop_data !== W'(i + 1)) begin
                n_fail++; $display("FAIL pop4_data[%0d] vld=%b data=%h want 1/%h", i, pop_data_vld, pop_data, W'(i + 1));
            end
        end
        n_checks++;
        if (empty !== 1'b1 || count !== 11'd0) begin
            n_fail++; $display("FAIL pop4_empty empty=%b count=%0d want 1/0", empty, count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 2000 && mq.size() < D; i++) begin
            drive(0, 1, W'($urandom), 0, 0);
            n_checks++;
            if (push_ack !== exp_pa) begin
                n_fail++; $display("FAIL fill_ack[%0d] got=%b want=%b", i, push_ack, exp_pa);
            end
            advance();
        end
        n_checks++;
        if (full !== 1'b1 || count !== 11'(D)) begin
            n_fail++; $display("FAIL full_flag full=%b count=%0d want 1/%0d", full, count, D);
        end
        drive(0, 1, W'($urandom), 0, 0);
        n_checks++;
        if (push_ack !== 1'b0 || ram_blk_select !== 1'b0) begin
            n_fail++; $display("FAIL full_stall ack=%b sel=%b want 0/0", push_ack, ram_blk_select);
        end
        advance();
        drive(0, 1, W'($urandom), 1, 0);
        n_checks++;
        if (pop_ack !== 1'b1 || push_ack !== 1'b0) begin
            n_fail++; $display("FAIL full_pop pop_ack=%b push_ack=%b want 1/0", pop_ack, push_ack);
        end
        advance();
        drive(0, 1, W'($urandom), 0, 0);
        n_checks++;
        if (push_ack !== 1'b1) begin
            n_fail++; $display("FAIL full_refill ack=%b want 1", push_ack);
        end
        advance();
        for (int i = 0; i < 2000 && mq.size() > 5; i++) begin
            drive(0, 0, '0, 1, 0);
            advance();
            n_checks++;
            if (pop_data_vld !== 1'b1 || pop_data !== exp_data) begin
                n_fail++; $display("FAIL drain_data[%0d] vld=%b data=%h want 1/%h", i, pop_data_vld, pop_data, exp_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit prev_push = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, W'($urandom), 1, 0);
            n_checks++;
            if (push_ack !== exp_pa || pop_ack !== exp_po || (ram_wr_en & ram_rd_en) !== 1'b0 ||
                (i > 0 && push_ack === prev_push)) begin
                n_fail++; $display("FAIL alternate[%0d] push=%b pop=%b want %b/%b (prev push %b)",
                                   i, push_ack, pop_ack, exp_pa, exp_po, prev_push);
            end
            prev_push = push_ack;
            advance();
            n_checks++;
            if ((count !== 11'd5 && count !== 11'd6) || count !== 11'(mq.size())) begin
                n_fail++; $display("FAIL alternate_count[%0d] got=%0d want %0d", i, count, mq.size());
            end
            if (exp_vld && pop_data !== exp_data) begin
                n_fail++; $display("FAIL alternate_data[%0d] got=%h want=%h", i, pop_data, exp_data);
            end
        end
    endtask

    task automatic test_wrap();
        bit wr_hit = 0, rd_hit = 0, wr_wrap = 0, rd_wrap = 0;
        for (int i = 0; i < 4000; i++) begin
            drive(0, $urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0, 0);
            n_checks++;
            if (push_ack !== exp_pa || pop_ack !== exp_po || ram_addr_wr !== A'(mwr) || ram_addr_rd !== A'(mrd)) begin
                n_fail++; $display("FAIL wrap_ctl[%0d] ack=%b%b addr=%0d/%0d want %b%b %0d/%0d",
                                   i, push_ack, pop_ack, ram_addr_wr, ram_addr_rd, exp_pa, exp_po, mwr, mrd);
            end
            wr_hit = push_ack && ram_addr_wr == A'(D - 1);
            rd_hit = pop_ack && ram_addr_rd == A'(D - 1);
            advance();
            if (wr_hit && ram_addr_wr == '0) wr_wrap = 1;
            if (rd_hit && ram_addr_rd == '0) rd_wrap = 1;
            n_checks++;
            if (pop_data_vld !== exp_vld || (exp_vld && pop_data !== exp_data)) begin
                n_fail++; $display("FAIL wrap_data[%0d] vld=%b data=%h want %b/%h", i, pop_data_vld, pop_data, exp_vld, exp_data);
            end
        end
        n_checks++;
        if ({wr_wrap, rd_wrap} !== 2'b11) begin
            n_fail++; $display("FAIL wrap_seen wr=%b rd=%b want 1/1", wr_wrap, rd_wrap);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2000 && mq.size() != 7; i++) begin
            drive(0, mq.size() < 7, W'($urandom), mq.size() > 7, 0);
            advance();
        end
        drive(0, 0, '0, 1, 0);
        advance();
        drive(0, 1, W'($urandom), 1, 1);
        n_checks++;
        if (push_ack !== 1'b0 || pop_ack !== 1'b0 || pop_data_vld !== 1'b1 || pop_data !== exp_data) begin
            n_fail++; $display("FAIL flush_cycle ack=%b%b vld=%b data=%h want 00/1/%h",
                               push_ack, pop_ack, pop_data_vld, pop_data, exp_data);
        end
        advance();
        n_checks++;
        if (count !== 11'd0 || empty !== 1'b1 || pop_data_vld !== 1'b0) begin
            n_fail++; $display("FAIL flush_after count=%0d empty=%b vld=%b want 0/1/0", count, empty, pop_data_vld);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, W'($urandom), 0, 0);
            advance();
        end
        drive(0, 0, '0, 1, 0);
        advance();
        drive(1, 1, W'($urandom), 0, 0);
        n_checks++;
        if (push_ack !== 1'b0 || pop_data_vld !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid ack=%b vld=%b want 0/1", push_ack, pop_data_vld);
        end
        advance();
        drive(0, 0, '0, 0, 0);
        n_checks++;
        if (count !== 11'd0 || empty !== 1'b1 || pop_data_vld !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_after count=%0d empty=%b vld=%b want 0/1/0", count, empty, pop_data_vld);
        end
        advance();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push_req = 1'b0; pop_req = 1'b0; push_data = '0;
        test_reset();
        test_push4();
        test_pop4();
        test_full();
        test_back_to_back();
        test_wrap();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
